// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM for the teaching processor: sequences fetch, decode,
// execute, data-memory access and register writeback from a 16-bit instruction.
module cpu_control_unit #(
    parameter int OPW  = 4,
    parameter int REGW = 4,
    parameter int IW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IW-1:0]   instr,
    input  logic            mem_ready,
    input  logic            alu_zero,
    output logic            imem_req,
    output logic            ir_load,
    output logic            pc_inc,
    output logic            pc_load,
    output logic [2:0]      alu_op,
    output logic            alu_src_imm,
    output logic [REGW-1:0] rs_addr,
    output logic [REGW-1:0] rt_addr,
    output logic [REGW-1:0] rd_addr,
    output logic            rf_we,
    output logic            rf_wsel,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            zero_flag,
    output logic            halted,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ir;
    logic            r_zero;
    logic [OPW-1:0]  w_op;
    logic            w_is_alu;

    logic            w_imem_req, w_ir_load, w_pc_inc, w_pc_load;
    logic [2:0]      w_alu_op;
    logic            w_alu_src_imm, w_rf_we, w_rf_wsel;
    logic            w_dmem_req, w_dmem_we, w_halted;

    assign w_op     = r_ir[IW-1 -: OPW];
    assign w_is_alu = (w_op >= 4'h1) && (w_op <= 4'h7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ir_load) begin
                r_ir <= instr;
            end
            if (r_state == S_EXECUTE && w_is_alu) begin
                r_zero <= alu_zero;
            end
        end
    end

    // Memory handshake: a request (imem_req/dmem_req) is held every cycle of the
    // wait and completes in the cycle mem_ready is high; there is no timeout.
    always_comb begin
        w_next        = r_state;
        w_imem_req    = 1'b0;
        w_ir_load     = 1'b0;
        w_pc_inc      = 1'b0;
        w_pc_load     = 1'b0;
        w_alu_op      = 3'd0;
        w_alu_src_imm = 1'b0;
        w_rf_we       = 1'b0;
        w_rf_wsel     = 1'b0;
        w_dmem_req    = 1'b0;
        w_dmem_we     = 1'b0;
        w_halted      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_load = 1'b1;
                    w_pc_inc  = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_op)
                    4'h0, 4'hC, 4'hD, 4'hE: w_next = S_FETCH;
                    4'h8, 4'h9:             w_next = S_MEM;
                    4'hF:                   w_next = S_HALT;
                    default:                w_next = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                case (w_op)
                    4'h2:    w_alu_op = 3'd1;
                    4'h3:    w_alu_op = 3'd2;
                    4'h4:    w_alu_op = 3'd3;
                    4'h5:    w_alu_op = 3'd4;
                    4'h7:    w_alu_op = 3'd7;
                    default: w_alu_op = 3'd0;
                endcase
                w_alu_src_imm = (w_op == 4'h6) || (w_op == 4'h7);
                // JZ tests the flag left by an earlier instruction, never its own.
                if (w_op == 4'hA) begin
                    w_pc_load = 1'b1;
                end else if (w_op == 4'hB) begin
                    w_pc_load = r_zero;
                end
                w_next = w_is_alu ? S_WRITEBACK : S_FETCH;
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (w_op == 4'h9);
                if (mem_ready) begin
                    w_next = (w_op == 4'h8) ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                w_rf_we   = 1'b1;
                w_rf_wsel = (w_op == 4'h8);
                w_next    = S_FETCH;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
        // Reset silences every strobe, dropping any request still in flight.
        if (rst) begin
            w_imem_req    = 1'b0;
            w_ir_load     = 1'b0;
            w_pc_inc      = 1'b0;
            w_pc_load     = 1'b0;
            w_alu_op      = 3'd0;
            w_alu_src_imm = 1'b0;
            w_rf_we       = 1'b0;
            w_rf_wsel     = 1'b0;
            w_dmem_req    = 1'b0;
            w_dmem_we     = 1'b0;
            w_halted      = 1'b0;
        end
    end

    assign imem_req    = w_imem_req;
    assign ir_load     = w_ir_load;
    assign pc_inc      = w_pc_inc;
    assign pc_load     = w_pc_load;
    assign alu_op      = w_alu_op;
    assign alu_src_imm = w_alu_src_imm;
    assign rf_we       = w_rf_we;
    assign rf_wsel     = w_rf_wsel;
    assign dmem_req    = w_dmem_req;
    assign dmem_we     = w_dmem_we;
    assign halted      = w_halted;
    assign zero_flag   = r_zero;
    assign state       = r_state;
    assign rs_addr     = r_ir[2*REGW-1 -: REGW];
    assign rt_addr     = r_ir[REGW-1:0];
    assign rd_addr     = r_ir[3*REGW-1 -: REGW];

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: per-instruction expected cycle traces are built
// from the instruction-class rules, then replayed against the DUT cycle by cycle.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;
    logic        imem_req, ir_load, pc_inc, pc_load;
    logic [2:0]  alu_op;
    logic        alu_src_imm;
    logic [3:0]  rs_addr, rt_addr, rd_addr;
    logic        rf_we, rf_wsel, dmem_req, dmem_we, zero_flag, halted;
    logic [2:0]  state;

    always #5 clk = ~clk;

    cpu_control_unit dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .imem_req(imem_req), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .rf_we(rf_we), .rf_wsel(rf_wsel), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .zero_flag(zero_flag), .halted(halted), .state(state)
    );

    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2;
    localparam logic [2:0] MEM = 3'd3, WRITEBACK = 3'd4, HALT = 3'd5;

    typedef struct packed {
        logic       imem_req, ir_load, pc_inc, pc_load;
        logic [2:0] alu_op;
        logic       alu_src_imm, rf_we, rf_wsel, dmem_req, dmem_we, halted;
    } strb_t;

    typedef struct {
        logic        rst, mr, az;
        logic [15:0] ins;
        strb_t       strb;
        logic [2:0]  st;
        logic        zf;
        bit          chk_st, chk_regs;
        logic [11:0] regs;
    } cyc_t;

    cyc_t  exp_q[$];
    strb_t act_strb;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    logic  m_zf = 1'b0;

    assign act_strb = {imem_req, ir_load, pc_inc, pc_load, alu_op,
                       alu_src_imm, rf_we, rf_wsel, dmem_req, dmem_we, halted};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Opcode to ALU function code: ADD=0 SUB=1 AND=2 OR=3 XOR=4 PASS_B=7.
    function automatic logic [2:0] exp_alu(input logic [3:0] op);
        case (op)
            4'h2:    return 3'd1;
            4'h3:    return 3'd2;
            4'h4:    return 3'd3;
            4'h5:    return 3'd4;
            4'h7:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    task automatic add_cyc(input logic r, input logic mr, input logic az, input logic [15:0] ins,
                           input strb_t s, input logic [2:0] st, input bit cs, input bit cr,
                           input logic [11:0] regs);
        cyc_t c;
        c.rst = r; c.mr = mr; c.az = az; c.ins = ins; c.strb = s; c.st = st;
        c.zf = m_zf; c.chk_st = cs; c.chk_regs = cr; c.regs = regs;
        exp_q.push_back(c);
    endtask

    task automatic model_reset(input int n);
        for (int i = 0; i < n; i++) begin
            add_cyc(1'b1, rb(), rb(), 16'($urandom), '0, FETCH, 1'b0, 1'b0, 12'h0);
        end
        m_zf = 1'b0;
    endtask

    task automatic model_fetch(input logic [15:0] ins, input int fwait);
        strb_t s;
        for (int i = 0; i < fwait; i++) begin
            s = '0; s.imem_req = 1'b1;
            add_cyc(1'b0, 1'b0, rb(), 16'($urandom), s, FETCH, 1'b1, 1'b0, 12'h0);
        end
        s = '0; s.imem_req = 1'b1; s.ir_load = 1'b1; s.pc_inc = 1'b1;
        add_cyc(1'b0, 1'b1, rb(), ins, s, FETCH, 1'b1, 1'b0, 12'h0);
        s = '0;
        add_cyc(1'b0, rb(), rb(), 16'($urandom), s, DECODE, 1'b1, 1'b1, ins[11:0]);
    endtask

    task automatic model_instr(input logic [15:0] ins, input int fwait, input int mwait,
                               input logic az);
        strb_t s;
        logic [3:0] op;
        op = ins[15:12];
        model_fetch(ins, fwait);
        if (op >= 4'h1 && op <= 4'h7) begin
            s = '0; s.alu_op = exp_alu(op); s.alu_src_imm = (op >= 4'h6);
            add_cyc(1'b0, rb(), az, 16'($urandom), s, EXECUTE, 1'b1, 1'b1, ins[11:0]);
            m_zf = az;
            s = '0; s.rf_we = 1'b1;
            add_cyc(1'b0, rb(), rb(), 16'($urandom), s, WRITEBACK, 1'b1, 1'b1, ins[11:0]);
        end else if (op == 4'hA || op == 4'hB) begin
            s = '0; s.pc_load = (op == 4'hA) ? 1'b1 : m_zf;
            add_cyc(1'b0, rb(), rb(), 16'($urandom), s, EXECUTE, 1'b1, 1'b1, ins[11:0]);
        end else if (op == 4'h8 || op == 4'h9) begin
            s = '0; s.dmem_req = 1'b1; s.dmem_we = (op == 4'h9);
            for (int i = 0; i < mwait; i++) begin
                add_cyc(1'b0, 1'b0, rb(), 16'($urandom), s, MEM, 1'b1, 1'b1, ins[11:0]);
            end
            add_cyc(1'b0, 1'b1, rb(), 16'($urandom), s, MEM, 1'b1, 1'b1, ins[11:0]);
            if (op == 4'h8) begin
                s = '0; s.rf_we = 1'b1; s.rf_wsel = 1'b1;
                add_cyc(1'b0, rb(), rb(), 16'($urandom), s, WRITEBACK, 1'b1, 1'b1, ins[11:0]);
            end
        end else if (op == 4'hF) begin
            s = '0; s.halted = 1'b1;
            for (int i = 0; i < 20; i++) begin
                add_cyc(1'b0, rb(), rb(), 16'($urandom), s, HALT, 1'b1, 1'b1, ins[11:0]);
            end
        end
    endtask

    task automatic run_q();
        cyc_t c;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            rst = c.rst; mem_ready = c.mr; alu_zero = c.az; instr = c.ins;
            @(negedge clk);
            total++;
            assert (act_strb === c.strb) else begin
                bad++;
                $error("FAIL strobes cyc=%0d act=%h exp=%h", cyc, act_strb, c.strb);
            end
            if (c.chk_st) begin
                total++;
                assert ({state, zero_flag} === {c.st, c.zf}) else begin
                    bad++;
                    $error("FAIL state_zf cyc=%0d act=%0d/%0b exp=%0d/%0b",
                           cyc, state, zero_flag, c.st, c.zf);
                end
            end
            if (c.chk_regs) begin
                total++;
                assert ({rd_addr, rs_addr, rt_addr} === c.regs) else begin
                    bad++;
                    $error("FAIL regs cyc=%0d act=%h exp=%h", cyc, {rd_addr, rs_addr, rt_addr}, c.regs);
                end
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset held, then ADD r1,r2,r3 with memory always ready.
        model_reset(3);
        model_instr(16'h1123, 0, 0, 1'b0);
        // LD with a slow data memory, then zero-flag driven branches.
        model_instr(16'h8450, 1, 3, 1'b0);
        model_instr(16'h2123, 0, 0, 1'b1);
        model_instr(16'hB00A, 0, 0, 1'b0);
        model_instr(16'h2456, 0, 0, 1'b0);
        model_instr(16'hB00A, 0, 0, 1'b1);
        // Store, undefined, NOP, jump and the remaining ALU forms.
        model_instr(16'h9023, 0, 0, 1'b0);
        model_instr(16'hC000, 0, 0, 1'b0);
        model_instr(16'h0000, 2, 0, 1'b0);
        model_instr(16'hA005, 0, 0, 1'b0);
        model_instr(16'h6125, 0, 0, 1'b1);
        model_instr(16'h7300, 0, 0, 1'b0);
        model_instr(16'h3456, 0, 0, 1'b1);
        model_instr(16'h4ABC, 0, 0, 1'b0);
        model_instr(16'h5DEF, 0, 0, 1'b1);
        run_q();
        // Random instruction stream, HALT excluded.
        for (int i = 0; i < 150; i++) begin
            model_instr({4'($urandom_range(0, 14)), 12'($urandom)},
                        int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rb());
            run_q();
        end
        // Reset while LD waits in MEM: flag set first so its clearing is visible.
        model_instr(16'h2111, 0, 0, 1'b1);
        model_fetch(16'h8450, 0);
        for (int i = 0; i < 2; i++) begin
            add_cyc(1'b0, 1'b0, rb(), 16'($urandom), '{dmem_req: 1'b1, default: '0},
                    MEM, 1'b1, 1'b1, 12'h450);
        end
        model_reset(1);
        model_instr(16'h1123, 0, 0, 1'b0);
        run_q();
        // HALT holds until reset, then normal fetch resumes.
        model_instr(16'hF000, 0, 0, 1'b0);
        model_reset(1);
        model_instr(16'h9023, 1, 1, 1'b0);
        run_q();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
